// File: rtl/trace_buffer.sv
// ---------------------------------------------------------------------------
// trace_buffer
//
// First-word-fall-through FIFO that decouples a trace unit from its consumer.
// Records are stored in a circular array; when the buffer is full and the
// consumer does not pop in the same cycle, the incoming record is dropped and
// a saturating 16-bit drop counter is incremented.
//
// Parameters
//   TRACE_WIDTH  width of one packed trace record
//   DEPTH        number of entries (power of two, >= 2)
//   CNT_WIDTH    width of the occupancy count (holds 0..DEPTH)
//
// Ports
//   clk_i          rising-edge clock
//   rst_ni         synchronous active-low reset
//   trace_valid_i  a record is offered this cycle
//   trace_i        record offered
//   flush_i        discard all buffered records at the next edge
//   out_valid_o    head record available (== !empty_o)
//   out_data_o     head record
//   out_ready_i    consumer takes the head record when out_valid_o is high
//   count_o        current occupancy
//   full_o         count_o == DEPTH
//   empty_o        count_o == 0
//   drop_count_o   saturating count of records lost to overflow
// ---------------------------------------------------------------------------
module trace_buffer #(
    parameter int TRACE_WIDTH = 128,
    parameter int DEPTH       = 16,
    parameter int CNT_WIDTH   = $clog2(DEPTH) + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   trace_valid_i,
    input  logic [TRACE_WIDTH-1:0] trace_i,
    input  logic                   flush_i,
    output logic                   out_valid_o,
    output logic [TRACE_WIDTH-1:0] out_data_o,
    input  logic                   out_ready_i,
    output logic [CNT_WIDTH-1:0]   count_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [15:0]            drop_count_o
);

    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);

    // Storage. Not reset: stale contents are never visible because
    // out_valid_o is derived from the occupancy count.
    logic [TRACE_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] count_q,  count_d;
    logic [15:0]          drop_q,   drop_d;

    logic is_full;
    logic is_empty;
    logic do_pop;
    logic do_push;
    logic do_drop;

    assign is_full  = (count_q == CNT_FULL);
    assign is_empty = (count_q == '0);

    // A pop frees a slot at the same edge, so a full buffer still accepts a
    // push when the consumer is taking the head.
    assign do_pop  = !is_empty && out_ready_i;
    assign do_push = trace_valid_i && (!is_full || do_pop);
    // A flush discards everything anyway, so a record refused during a flush
    // is not counted as an overflow loss.
    assign do_drop = trace_valid_i && !do_push && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are log2(DEPTH) bits wide, so DEPTH-1 -> 0 wraps
            // naturally.
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_WIDTH'(1);
                2'b01:   count_d = count_q - CNT_WIDTH'(1);
                default: count_d = count_q;
            endcase
        end

        if (do_drop && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // Write port. Writes landing during a flush or reset are harmless: the
    // pointers and count are cleared at the same edge, so the slot is
    // treated as free.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= trace_i;
        end
    end

    // Fall-through read of the head slot. The slot is written at an edge
    // and only becomes visible after it, so there is no same-cycle bypass.
    assign out_data_o   = mem_q[rd_ptr_q];
    assign out_valid_o  = !is_empty;
    assign count_o      = count_q;
    assign full_o       = is_full;
    assign empty_o      = is_empty;
    assign drop_count_o = drop_q;

endmodule

// File: tb/tb_trace_buffer.sv
// ---------------------------------------------------------------------------
// tb_trace_buffer
//
// Self-checking bench for trace_buffer (DEPTH=4, TRACE_WIDTH=128). A queue
// based reference model tracks expected contents and drop count; every
// cycle the DUT outputs are compared against it, and directed scenarios add
// explicit constant checks on top.
// ---------------------------------------------------------------------------
module tb_trace_buffer;

    localparam int TW    = 128;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          trace_valid_i = 1'b0;
    logic [TW-1:0] trace_i = '0;
    logic          flush_i = 1'b0;
    logic          out_valid_o;
    logic [TW-1:0] out_data_o;
    logic          out_ready_i = 1'b0;
    logic [CW-1:0] count_o;
    logic          full_o;
    logic          empty_o;
    logic [15:0]   drop_count_o;

    trace_buffer #(
        .TRACE_WIDTH(TW),
        .DEPTH      (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .trace_valid_i(trace_valid_i),
        .trace_i      (trace_i),
        .flush_i      (flush_i),
        .out_valid_o  (out_valid_o),
        .out_data_o   (out_data_o),
        .out_ready_i  (out_ready_i),
        .count_o      (count_o),
        .full_o       (full_o),
        .empty_o      (empty_o),
        .drop_count_o (drop_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: records in arrival order plus saturating drop count.
    logic [TW-1:0] model_q[$];
    int            model_drops = 0;
    bit            model_known = 1'b0;
    bit            verbose     = 1'b1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output with the model (outputs depend on state only).
    task automatic check_model();
        bit nonempty;
        if (!model_known) return;
        nonempty = (model_q.size() != 0);
        check("out_valid", TW'(out_valid_o), TW'(nonempty));
        if (nonempty) check("out_data", out_data_o, model_q[0]);
        check("count", TW'(count_o), TW'(model_q.size()));
        check("full", TW'(full_o), TW'(model_q.size() == DEPTH));
        check("empty", TW'(empty_o), TW'(!nonempty));
        check("drop_count", TW'(drop_count_o), TW'(model_drops));
    endtask

    // What one rising edge does, expressed as FIFO rules on the queue.
    task automatic model_edge(input logic v, input logic [TW-1:0] d, input logic r,
                              input logic f, input logic rn);
        bit pop;
        bit push;
        if (!rn) begin
            model_q.delete();
            model_drops = 0;
            model_known = 1'b1;
        end else if (f) begin
            model_q.delete();
        end else begin
            pop  = (model_q.size() > 0) && r;
            push = v && ((model_q.size() < DEPTH) || pop);
            if (pop) void'(model_q.pop_front());
            if (push) model_q.push_back(d);
            else if (v && model_drops < 65535) model_drops++;
        end
    endtask

    // One clock cycle: drive at the falling edge, check, take the rising
    // edge, update the model, then settle 1 time unit past the edge.
    task automatic step(input logic v, input logic [TW-1:0] d, input logic r,
                        input logic f, input logic rn);
        @(negedge clk_i);
        trace_valid_i = v;
        trace_i       = d;
        out_ready_i   = r;
        flush_i       = f;
        rst_ni        = rn;
        check_model();
        if (verbose)
            $display("t=%0t valid=%0b data=%0h ready=%0b flush=%0b rst_n=%0b | head=%0h cnt=%0d drops=%0d",
                     $time, v, d, r, f, rn, out_data_o, count_o, drop_count_o);
        @(posedge clk_i);
        model_edge(v, d, r, f, rn);
        #1;
    endtask

    initial begin
        // Reset
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("rst_valid", TW'(out_valid_o), TW'(0));
        check("rst_empty", TW'(empty_o), TW'(1));
        check("rst_full", TW'(full_o), TW'(0));
        check("rst_drop", TW'(drop_count_o), TW'(0));

        // Three pushes held, then drained on consecutive edges
        step(1'b1, TW'('hA1), 1'b0, 1'b0, 1'b1);
        step(1'b1, TW'('hA2), 1'b0, 1'b0, 1'b1);
        step(1'b1, TW'('hA3), 1'b0, 1'b0, 1'b1);
        check("hold3_count", TW'(count_o), TW'(3));
        check("hold3_head", out_data_o, TW'('hA1));
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        check("drain_head2", out_data_o, TW'('hA2));
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        check("drain_head3", out_data_o, TW'('hA3));
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        check("drain_empty", TW'(empty_o), TW'(1));

        // Overflow: six pushes into four slots
        for (int i = 0; i < 6; i++) begin
            step(1'b1, TW'('h10 + i), 1'b0, 1'b0, 1'b1);
            if (i == 3) check("ovf_full", TW'(full_o), TW'(1));
        end
        check("ovf_drops", TW'(drop_count_o), TW'(2));

        // Full with simultaneous push and pop: no drop, count stays 4
        step(1'b1, TW'('h20), 1'b1, 1'b0, 1'b1);
        check("fullpp_count", TW'(count_o), TW'(4));
        check("fullpp_drops", TW'(drop_count_o), TW'(2));
        check("fullpp_head", out_data_o, TW'('h11));
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        check("fullpp_0x20", out_data_o, TW'('h20));
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);

        // Sustained push+pop with two preloaded records; pointers wrap
        step(1'b1, TW'('h40), 1'b0, 1'b0, 1'b1);
        step(1'b1, TW'('h41), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, TW'('h50 + i), 1'b1, 1'b0, 1'b1);
            check("stream_count", TW'(count_o), TW'(2));
        end
        check("stream_drops", TW'(drop_count_o), TW'(2));
        step(1'b1, '0, 1'b0, 1'b1, 1'b1);

        // Flush with a same-cycle push: record 0x30 must vanish
        step(1'b1, TW'('h31), 1'b0, 1'b0, 1'b1);
        step(1'b1, TW'('h32), 1'b0, 1'b0, 1'b1);
        step(1'b1, TW'('h33), 1'b0, 1'b0, 1'b1);
        step(1'b1, TW'('h30), 1'b1, 1'b1, 1'b1);
        check("flush_count", TW'(count_o), TW'(0));
        check("flush_valid", TW'(out_valid_o), TW'(0));
        check("flush_drops", TW'(drop_count_o), TW'(2));
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0),
                 {$urandom, $urandom, $urandom, $urandom},
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 40) == 0),
                 1'($urandom_range(0, 80) != 0));
        end

        // Drop counter saturation
        verbose = 1'b0;
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4 + 65534; i++)
            step(1'b1, TW'($urandom), 1'b0, 1'b0, 1'b1);
        check("sat_fffe", TW'(drop_count_o), TW'(16'hFFFE));
        verbose = 1'b1;
        for (int i = 0; i < 3; i++)
            step(1'b1, TW'($urandom), 1'b0, 1'b0, 1'b1);
        check("sat_ffff", TW'(drop_count_o), TW'(16'hFFFF));
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("sat_reset", TW'(drop_count_o), TW'(0));
        check("sat_reset_empty", TW'(empty_o), TW'(1));
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
